// File: rtl/stoch_pkg.sv
// Shared constants, lane seeds, FSM state type and LFSR step function
// for the stochastic stream generator.
package stoch_pkg;

  localparam int LFSR_W  = 8;
  localparam int N_LANES = 4;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 8'hB8;

  // Lane 0 entry is overridden by the top-level SEED parameter.
  localparam logic [LFSR_W-1:0] LANE_SEED [0:N_LANES-1] = '{8'h01, 8'h5A, 8'hA7, 8'hE3};

  typedef enum logic [1:0] {IDLE, GEN, DONE} gen_state_e;

  // Galois right shift: x^8+x^6+x^5+x^4+1, never reaches zero from a non-zero state.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/stoch_lfsr8.sv
// 8-bit Galois LFSR with synchronous reload (priority over step) and
// asynchronous reset to its own seed value.
module stoch_lfsr8
  import stoch_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_VAL = 8'h01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/stoch_stream_gen.sv
// Four-lane probability-to-bitstream converter with valid/ready on both sides.
// Build option: STOCH_DECORR_EN gives each lane its own LFSR; otherwise one LFSR is shared.
module stoch_stream_gen
  import stoch_pkg::*;
#(
  parameter int               STREAM_LEN = 256,
  parameter logic [LFSR_W-1:0] SEED      = 8'h01
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           prob,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [STREAM_LEN-1:0] array1,
  output logic [STREAM_LEN-1:0] array2,
  output logic [STREAM_LEN-1:0] array3,
  output logic [STREAM_LEN-1:0] array4
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and a raised out_valid holds with stable data until taken.

  localparam int CW = $clog2(STREAM_LEN);
  localparam logic [CW-1:0] LAST = CW'(STREAM_LEN - 1);

  gen_state_e state, state_d;
  logic [CW-1:0] cnt;
  logic [31:0] prob_q;
  logic [N_LANES-1:0][STREAM_LEN-1:0] arr;
  logic [LFSR_W-1:0] lfsr_val [N_LANES];
  logic accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_d = GEN;
      end
      GEN: begin
        if (cnt == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef STOCH_DECORR_EN
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane_lfsr
    localparam logic [LFSR_W-1:0] LSEED = (k == 0) ? SEED : LANE_SEED[k];
    stoch_lfsr8 #(.RESET_VAL(LSEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .seed  (LSEED),
      .step  (state == GEN),
      .q     (lfsr_val[k])
    );
  end
`else
  logic [LFSR_W-1:0] shared_q;
  stoch_lfsr8 #(.RESET_VAL(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .seed  (SEED),
    .step  (state == GEN),
    .q     (shared_q)
  );
  // All comparators see the same sequence, so lane streams are nested by probability.
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane_share
    assign lfsr_val[k] = shared_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prob_q <= '0;
      cnt    <= '0;
      arr    <= '0;
    end else if (accept) begin
      prob_q <= prob;
      cnt    <= '0;
      arr    <= '0;
    end else if (state == GEN) begin
      for (int k = 0; k < N_LANES; k++) begin
        arr[k][cnt] <= (lfsr_val[k] <= prob_q[LFSR_W*k +: LFSR_W]);
      end
      if (cnt != LAST) cnt <= cnt + 1'b1;
    end
  end

  assign array1 = arr[0];
  assign array2 = arr[1];
  assign array3 = arr[2];
  assign array4 = arr[3];

endmodule

// File: doc/stoch_stream_gen.md
Name: stoch_stream_gen

Overview:
- Upstream feeder of the first-one/stochastic-sum stage.
- Converts four 8-bit probabilities into four STREAM_LEN-bit stochastic bitstreams, one bit per lane per cycle. Each bit comes from an LFSR-vs-probability comparison.
- Presents the four completed streams in parallel on array1..array4 with a valid/ready handshake.
- Sits between the probability source (memory readout or controller) and the find-first-one stage.

Parameters:
- STREAM_LEN, 256, bits per stream; must equal the array width of the downstream stage; power of two, 2..256.
- SEED, 8'h01, LFSR reload value for lane 0 (and all lanes when decorrelation is off); must be non-zero.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  probability word valid.
- in_ready  out  1  block can accept a probability word.
- prob  in  32  lane k probability is prob[8k+7:8k], k=0..3, unsigned 0..255.
- out_valid  out  1  array1..array4 hold a complete batch.
- out_ready  in  1  consumer accepts the batch.
- array1..array4  out  STREAM_LEN each  generated streams for lanes 0..3.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, in_ready=1, out_valid=0, arrays=0, cnt=0, LFSRs=seed values, prob_q=0.
- FSM states: IDLE, GEN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch prob into prob_q, clear all arrays, cnt=0, reload all LFSRs to their seeds, go to GEN.
- GEN:
  - in_ready=0, out_valid=0.
  - Each cycle: arrayk[cnt] <= (lfsr_k <= prob_q[k]). Other bits are unchanged. Each LFSR then advances one step and cnt increments.
  - At cnt==STREAM_LEN-1, write the last bit and go to DONE.
- DONE:
  - out_valid=1; arrays stable.
  - On out_ready go to IDLE; out_valid drops the next cycle.
  - in_ready=0 throughout DONE, so a same-cycle in_valid is not accepted. It is accepted in the following IDLE cycle.
- Latency: handshake accept at cycle T gives first out_valid at T+STREAM_LEN+1.
- Throughput: one batch per STREAM_LEN+2 cycles with out_ready tied high.
- Bit order: bit generated first goes to index 0, so the downstream "first one" is the earliest-generated one.
- LFSR:
  - 8-bit Galois, right shift, feedback mask 8'hB8 (x^8+x^6+x^5+x^4+1); period 255, never zero.
  - Reloaded at every accept, so output is deterministic per prob.
- Comparison is unsigned "lfsr <= p":
  - p=0 gives an all-zero stream.
  - p=255 gives an all-one stream.
  - For STREAM_LEN=256, popcount = p + (seed<=p), because the seed state repeats at index 255.
- cnt width is $clog2(STREAM_LEN). No wrap is used; the transition out of GEN happens at LEN-1.
- Reset mid-GEN or mid-DONE: batch discarded, outputs return to reset values, no partial out_valid.
- in_valid held high across a batch: exactly one accept per IDLE visit.
- prob changes while not in IDLE: ignored (prob_q holds).

Optional Feature:
- Macro STOCH_DECORR_EN.
- Defined:
  - Four independent LFSRs.
  - Lane 0 reloads to SEED; lanes 1..3 reload to package constants LANE_SEED[1..3] = 8'h5A, 8'hA7, 8'hE3.
  - Lanes carry uncorrelated streams.
- Undefined:
  - One shared LFSR seeded with SEED feeds all four comparators, so the streams are maximally correlated.
  - Saves about 24 flops.
- Handshake, timing and popcount rule per lane are identical in both builds, using that lane's seed in the formula.

Decomposition:
- Package stoch_pkg holds:
  - LFSR_W=8, LFSR_MASK=8'hB8, LANE_SEED[0:3] array, N_LANES=4.
  - State enum typedef gen_state_e {IDLE, GEN, DONE}.
- One sub-module, stoch_lfsr8: ports clk, rst_n, load, seed, step, q. It is instantiated once or four times depending on STOCH_DECORR_EN.

Test Plan:
- Reset, then prob=32'h00_00_00_00 accepted, out_ready=1:
  - All arrays 0.
  - out_valid high exactly 257 cycles after the accept.
  - in_ready low from accept until back in IDLE.
- prob=32'hFF_FF_FF_FF: all four arrays all-ones (256 ones each).
- prob=32'h80_40_20_01, SEED=1, macro off:
  - Popcounts 129/65/33/2 for lanes 3..0.
  - Every array is a subset of the next-higher-probability array (shared LFSR).
- Backpressure: out_ready=0 for 50 cycles in DONE.
  - out_valid and arrays stable throughout; in_valid pulses ignored.
  - After out_ready=1, the next in_valid is accepted one cycle later.
- Assert rst_n=0 at cnt=100 mid-GEN: outputs zero immediately (async), state IDLE, a new batch completes normally.
- Macro on, prob=32'h80_80_80_80: lanes 0..3 arrays pairwise differ, each popcount = 128 + (lane_seed<=128).
